bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 85 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3), with
// overflow flagging above 9999 and optional leading-zero blanking.
module bin_to_bcd_seq #(
  parameter bit BLANK_LEAD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [13:0] sr;
  logic [15:0] scratch;
  logic        big;
  logic [15:0] adj;

  // Add-3 correction so each digit carries correctly on the following shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++)
      if (scratch[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
  end

  // Leading zeros from thousands down become 4'hF; units always stays numeric.
  function automatic logic [15:0] blank_lead(input logic [15:0] d);
    logic [15:0] r;
    logic        lead;
    r    = d;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && d[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      sr      <= 14'd0;
      scratch <= 16'd0;
      big     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= 16'h0000;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sr      <= bin;
          big     <= (bin > 14'd9999);
          scratch <= 16'd0;
          cnt     <= 4'd0;
          busy    <= 1'b1;
          state   <= CONV;
        end
        CONV: begin
          scratch <= {adj[14:0], sr[13]};
          sr      <= {sr[12:0], 1'b0};
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd13) state <= FIN;
        end
        FIN: begin
          ovf   <= big;
          bcd   <= big ? 16'hFFFF : (BLANK_LEAD ? blank_lead(scratch) : scratch);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: one unblanked and one blanked instance
// share the same stimulus and are checked against hand-computed results.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [13:0] bin;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [15:0] bcd0, bcd1;

  int tests = 0;
  int fails = 0;

  bin_to_bcd_seq #(.BLANK_LEAD(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0));

  bin_to_bcd_seq #(.BLANK_LEAD(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Full conversion from IDLE; bin is scrambled mid-conversion to prove it is ignored.
  task automatic run_conv(input string tag, input logic [13:0] v,
                          input logic [15:0] e0, input logic [15:0] e1, input logic eo);
    int k;
    logic busy_ok;
    bin = v;
    start = 1'b1;
    step();
    start = 1'b0;
    bin = ~v;
    chk({tag, "_busy_e0"}, {30'd0, busy0, busy1}, 32'h3);
    busy_ok = 1'b1;
    for (k = 1; k <= 20; k++) begin
      step();
      if (done0) break;
      if (!(busy0 && busy1) || done1) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, k, 15);
    chk({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_done1"}, {31'd0, done1}, 32'd1);
    chk({tag, "_busy_fin"}, {30'd0, busy0, busy1}, 32'h0);
    chk({tag, "_bcd0"}, {16'd0, bcd0}, {16'd0, e0});
    chk({tag, "_bcd1"}, {16'd0, bcd1}, {16'd0, e1});
    chk({tag, "_ovf"}, {30'd0, ovf0, ovf1}, {30'd0, eo, eo});
    step();
    chk({tag, "_done_pulse"}, {30'd0, done0, done1}, 32'h0);
    chk({tag, "_hold"}, {bcd0, bcd1}, {e0, e1});
  endtask

  initial begin
    int dn, de;
    logic [13:0] vals [3];
    logic [15:0] ex0 [3];
    logic [15:0] ex1 [3];
    int edges [3];

    rst = 1'b1; start = 1'b0; bin = 14'd0;
    repeat (2) step();
    chk("rst_busy_done", {28'd0, busy0, busy1, done0, done1}, 32'h0);
    chk("rst_bcd", {bcd0, bcd1}, 32'h0);
    chk("rst_ovf", {30'd0, ovf0, ovf1}, 32'h0);
    rst = 1'b0;
    step();

    run_conv("c1234", 14'd1234, 16'h1234, 16'h1234, 1'b0);
    run_conv("c0",    14'd0,    16'h0000, 16'hFFF0, 1'b0);
    run_conv("c7",    14'd7,    16'h0007, 16'hFFF7, 1'b0);
    run_conv("c305",  14'd305,  16'h0305, 16'hF305, 1'b0);
    run_conv("c9999", 14'd9999, 16'h9999, 16'h9999, 1'b0);
    run_conv("c10000", 14'd10000, 16'hFFFF, 16'hFFFF, 1'b1);
    run_conv("c16383", 14'd16383, 16'hFFFF, 16'hFFFF, 1'b1);
    run_conv("c1000", 14'd1000, 16'h1000, 16'h1000, 1'b0);
    run_conv("c80",   14'd80,   16'h0080, 16'hFF80, 1'b0);

    // Restart while busy is ignored; restart in the done cycle is accepted.
    bin = 14'd42; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    bin = 14'd999; start = 1'b1;
    step();
    start = 1'b0;
    dn = 0; de = 0;
    for (int e = 6; e <= 15; e++) begin
      step();
      if (done0) begin dn++; de = e; end
    end
    chk("rs_done_count", dn, 1);
    chk("rs_done_edge", de, 15);
    chk("rs_bcd42", {bcd0, bcd1}, {16'h0042, 16'hFF42});
    bin = 14'd999; start = 1'b1;
    step();
    start = 1'b0;
    dn = 0; de = 0;
    for (int e = 17; e <= 35; e++) begin
      step();
      if (done0) begin dn++; de = e; end
    end
    chk("rs2_done_count", dn, 1);
    chk("rs2_done_edge", de, 31);
    chk("rs2_bcd999", {bcd0, bcd1}, {16'h0999, 16'hF999});

    // Reset in the middle of a conversion aborts it.
    bin = 14'd5678; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab_busy_done", {28'd0, busy0, busy1, done0, done1}, 32'h0);
    chk("ab_bcd", {bcd0, bcd1}, 32'h0);
    dn = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (done0 || done1 || busy0) dn++;
    end
    chk("ab_no_done", dn, 0);
    run_conv("c5678", 14'd5678, 16'h5678, 16'h5678, 1'b0);

    // start held high: back-to-back conversions every 16 edges.
    vals[0] = 14'd100;  ex0[0] = 16'h0100; ex1[0] = 16'hF100;
    vals[1] = 14'd2024; ex0[1] = 16'h2024; ex1[1] = 16'h2024;
    vals[2] = 14'd8765; ex0[2] = 16'h8765; ex1[2] = 16'h8765;
    edges[0] = 0; edges[1] = 0; edges[2] = 0;
    dn = 0;
    bin = vals[0]; start = 1'b1;
    step();
    for (int e = 1; e <= 47; e++) begin
      step();
      if (e == 20) chk("bb_hold", {bcd0, bcd1}, {ex0[0], ex1[0]});
      if (done0) begin
        if (dn < 3) begin
          edges[dn] = e;
          chk("bb_bcd", {bcd0, bcd1}, {ex0[dn], ex1[dn]});
        end
        dn++;
        if (dn < 3) bin = vals[dn];
      end
    end
    start = 1'b0;
    chk("bb_count", dn, 3);
    chk("bb_edge0", edges[0], 15);
    chk("bb_edge1", edges[1], 31);
    chk("bb_edge2", edges[2], 47);
    step();
    chk("bb_idle", {30'd0, busy0, done0}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
